// File: rtl/run_signature_monitor_if.sv
// Kernel-output stream, run handshake, expected values and run results between the
// kernel wrapper's reduction stage and the run signature monitor.
interface run_signature_monitor_if #(
  parameter int BEAT_W = 16,
  parameter int CYC_W  = 32
);
  logic              ap_start;
  logic              ap_done;
  logic [3:0]        data_in;
  logic              data_valid;
  logic [31:0]       exp_sig;
  logic [BEAT_W-1:0] exp_beats;
  logic              busy;
  logic              result_valid;
  logic              pass;
  logic [31:0]       sig_out;
  logic [BEAT_W-1:0] beat_cnt_out;
  logic [CYC_W-1:0]  cycle_cnt_out;
  logic [15:0]       run_cnt;
  logic              stray;

  modport master (
    output ap_start, ap_done, data_in, data_valid, exp_sig, exp_beats,
    input  busy, result_valid, pass, sig_out, beat_cnt_out, cycle_cnt_out, run_cnt, stray
  );

  modport slave (
    input  ap_start, ap_done, data_in, data_valid, exp_sig, exp_beats,
    output busy, result_valid, pass, sig_out, beat_cnt_out, cycle_cnt_out, run_cnt, stray
  );
endinterface

// File: rtl/run_signature_monitor.sv
// Per-run MISR signature, beat and cycle counters with expected-value compare; result strobe
// DRAIN_CYCLES+2 cycles after ap_done. No backpressure: every valid beat is accepted.
module run_signature_monitor #(
  parameter logic [31:0] SEED         = 32'hFFFFFFFF,
  parameter logic [31:0] POLY         = 32'h04C11DB7,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          BEAT_W       = 16,
  parameter int          CYC_W        = 32
) (
  input logic                    ap_clk,
  input logic                    ap_rst,
  run_signature_monitor_if.slave bus
);
  localparam int DCNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]        r_state;
  logic [31:0]       r_sig;
  logic [BEAT_W-1:0] r_beat;
  logic [CYC_W-1:0]  r_cyc;
  logic [DCNT_W-1:0] r_dcnt;
  logic              r_pass;
  logic [31:0]       r_sig_out;
  logic [BEAT_W-1:0] r_beat_out;
  logic [CYC_W-1:0]  r_cyc_out;
  logic [15:0]       r_run_cnt;
  logic              r_stray;

  logic [31:0]       w_fold;
  logic [31:0]       w_sig_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              w_beat_ovf;
  logic              w_cyc_ovf;

  assign w_fold     = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ {28'h0, bus.data_in};
  assign w_sig_nxt  = bus.data_valid ? w_fold : r_sig;
  assign w_beat_ovf = bus.data_valid && (&r_beat);
  assign w_beat_nxt = (bus.data_valid && !(&r_beat)) ? r_beat + BEAT_W'(1) : r_beat;
  assign w_cyc_ovf  = &r_cyc;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state    <= S_IDLE;
      r_sig      <= SEED;
      r_beat     <= '0;
      r_cyc      <= '0;
      r_dcnt     <= '0;
      r_pass     <= 1'b0;
      r_sig_out  <= '0;
      r_beat_out <= '0;
      r_cyc_out  <= '0;
      r_run_cnt  <= '0;
      r_stray    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.data_valid) r_stray <= 1'b1;
          if (bus.ap_start) begin
            r_state <= S_RUN;
            r_sig   <= SEED;
            r_beat  <= '0;
            r_cyc   <= CYC_W'(1);
          end
        end
        S_RUN: begin
          r_sig  <= w_sig_nxt;
          r_beat <= w_beat_nxt;
          if (!w_cyc_ovf) r_cyc <= r_cyc + CYC_W'(1);
          if (w_cyc_ovf || w_beat_ovf) r_stray <= 1'b1;
          // done wins over a simultaneous start; start is not looked at here
          if (bus.ap_done) begin
            r_state <= S_DRAIN;
            r_dcnt  <= DCNT_W'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          r_sig  <= w_sig_nxt;
          r_beat <= w_beat_nxt;
          if (w_beat_ovf) r_stray <= 1'b1;
          if (r_dcnt == '0) begin
            r_state    <= S_REPORT;
            r_sig_out  <= w_sig_nxt;
            r_beat_out <= w_beat_nxt;
            r_cyc_out  <= r_cyc;
            r_pass     <= (w_sig_nxt == bus.exp_sig) && (w_beat_nxt == bus.exp_beats);
            r_run_cnt  <= r_run_cnt + 16'd1;
          end else begin
            r_dcnt <= r_dcnt - DCNT_W'(1);
          end
        end
        default: begin
          if (bus.data_valid) r_stray <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.result_valid  = (r_state == S_REPORT);
  assign bus.pass          = r_pass;
  assign bus.sig_out       = r_sig_out;
  assign bus.beat_cnt_out  = r_beat_out;
  assign bus.cycle_cnt_out = r_cyc_out;
  assign bus.run_cnt       = r_run_cnt;
  assign bus.stray         = r_stray;
endmodule

// File: tb/tb_run_signature_monitor.sv
// Directed bench for run_signature_monitor: hand-computed signatures, counts and strobe timing.
module tb_run_signature_monitor;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rv_count = 0;
  int   rv_mark;
  int   lat;

  run_signature_monitor_if #(.BEAT_W(16), .CYC_W(32)) bus ();

  run_signature_monitor dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.result_valid === 1'b1) rv_count++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // raise ap_done for one cycle, then count cycles until the result strobe (bounded)
  task automatic done_and_wait(input logic keep_start, output int cycles);
    bus.ap_done  = 1'b1;
    bus.ap_start = keep_start;
    cycles = 0;
    do begin
      step();
      bus.ap_done = 1'b0;
      cycles++;
    end while (bus.result_valid !== 1'b1 && cycles < 40);
  endtask

  initial begin
    rst            = 1'b1;
    bus.ap_start   = 1'b0;
    bus.ap_done    = 1'b0;
    bus.data_in    = 4'h0;
    bus.data_valid = 1'b0;
    bus.exp_sig    = 32'h0;
    bus.exp_beats  = 16'h0;
    repeat (2) step();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rv", bus.result_valid, 1'b0);
    check("rst_pass", bus.pass, 1'b0);
    check("rst_sig", bus.sig_out, 32'h0);
    check("rst_beats", bus.beat_cnt_out, 16'h0);
    check("rst_cyc", bus.cycle_cnt_out, 32'h0);
    check("rst_runs", bus.run_cnt, 16'h0);
    check("rst_stray", bus.stray, 1'b0);
    rst = 1'b0;
    step();

    // Run 1: no beats, done in the 10th cycle counting the start cycle
    bus.exp_sig   = 32'hFFFFFFFF;
    bus.exp_beats = 16'd0;
    bus.ap_start  = 1'b1;
    step();
    check("t1_busy", bus.busy, 1'b1);
    repeat (8) step();
    done_and_wait(1'b0, lat);
    check("t1_latency", lat, 5);
    check("t1_rv", bus.result_valid, 1'b1);
    check("t1_busy_report", bus.busy, 1'b0);
    check("t1_sig", bus.sig_out, 32'hFFFFFFFF);
    check("t1_beats", bus.beat_cnt_out, 16'd0);
    check("t1_cyc", bus.cycle_cnt_out, 32'd10);
    check("t1_pass", bus.pass, 1'b1);
    check("t1_runs", bus.run_cnt, 16'd1);
    check("t1_stray", bus.stray, 1'b0);
    step();
    check("t1_rv_one_cycle", bus.result_valid, 1'b0);
    check("t1_pass_held", bus.pass, 1'b1);

    // Run 2: single beat 5 -> FB3EE24C, expected value off by one bit
    bus.exp_sig   = 32'hFB3EE24D;
    bus.exp_beats = 16'd1;
    bus.ap_start  = 1'b1;
    step();
    bus.data_valid = 1'b1;
    bus.data_in    = 4'h5;
    step();
    bus.data_valid = 1'b0;
    step();
    done_and_wait(1'b0, lat);
    check("t2_latency", lat, 5);
    check("t2_sig", bus.sig_out, 32'hFB3EE24C);
    check("t2_beats", bus.beat_cnt_out, 16'd1);
    check("t2_cyc", bus.cycle_cnt_out, 32'd4);
    check("t2_pass", bus.pass, 1'b0);
    check("t2_runs", bus.run_cnt, 16'd2);
    step();

    // Run 3: beats at done+1 (3) and done+4 (A) counted, done+5 dropped as stray
    bus.exp_sig   = 32'hF2BCD929;
    bus.exp_beats = 16'd2;
    bus.ap_start  = 1'b1;
    step();
    step();
    bus.ap_done  = 1'b1;
    bus.ap_start = 1'b0;
    step();
    bus.ap_done = 1'b0;
    check("t3_busy_drain", bus.busy, 1'b1);
    bus.data_valid = 1'b1;
    bus.data_in    = 4'h3;
    step();
    bus.data_valid = 1'b0;
    step();
    step();
    bus.data_valid = 1'b1;
    bus.data_in    = 4'hA;
    step();
    check("t3_rv", bus.result_valid, 1'b1);
    check("t3_stray_before", bus.stray, 1'b0);
    bus.data_in = 4'h7;
    step();
    bus.data_valid = 1'b0;
    check("t3_rv_low", bus.result_valid, 1'b0);
    check("t3_stray", bus.stray, 1'b1);
    check("t3_beats", bus.beat_cnt_out, 16'd2);
    check("t3_sig", bus.sig_out, 32'hF2BCD929);
    check("t3_cyc", bus.cycle_cnt_out, 32'd3);
    check("t3_pass", bus.pass, 1'b1);
    check("t3_runs", bus.run_cnt, 16'd3);

    // Reset mid-run after four beats
    bus.ap_start = 1'b1;
    step();
    bus.data_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.data_in = 4'(i);
      step();
    end
    bus.data_valid = 1'b0;
    check("t5_busy_run", bus.busy, 1'b1);
    rv_mark = rv_count;
    rst = 1'b1;
    #2;
    check("t5_busy", bus.busy, 1'b0);
    check("t5_rv", bus.result_valid, 1'b0);
    check("t5_pass", bus.pass, 1'b0);
    check("t5_sig", bus.sig_out, 32'h0);
    check("t5_beats", bus.beat_cnt_out, 16'h0);
    check("t5_cyc", bus.cycle_cnt_out, 32'h0);
    check("t5_runs", bus.run_cnt, 16'h0);
    check("t5_stray", bus.stray, 1'b0);
    step();
    step();
    bus.ap_start = 1'b0;
    rst = 1'b0;
    step();
    check("t5_no_strobe", rv_count, rv_mark);
    bus.exp_sig   = 32'hFB3EE24C;
    bus.exp_beats = 16'd1;
    bus.ap_start  = 1'b1;
    step();
    bus.data_valid = 1'b1;
    bus.data_in    = 4'h5;
    step();
    bus.data_valid = 1'b0;
    done_and_wait(1'b0, lat);
    check("t5b_sig", bus.sig_out, 32'hFB3EE24C);
    check("t5b_beats", bus.beat_cnt_out, 16'd1);
    check("t5b_cyc", bus.cycle_cnt_out, 32'd3);
    check("t5b_pass", bus.pass, 1'b1);
    check("t5b_runs", bus.run_cnt, 16'd1);
    step();

    // Three back-to-back 20-cycle runs with ap_start held high
    bus.exp_sig   = 32'hFFFFFFFF;
    bus.exp_beats = 16'd0;
    rv_mark       = rv_count;
    bus.ap_start  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      check("t4_busy_run", bus.busy, 1'b1);
      repeat (18) step();
      done_and_wait(r < 2, lat);
      check("t4_latency", lat, 5);
      check("t4_cyc", bus.cycle_cnt_out, 32'd20);
      check("t4_pass", bus.pass, 1'b1);
      check("t4_busy_report", bus.busy, 1'b0);
      step();
      check("t4_busy_gap", bus.busy, 1'b0);
      check("t4_rv_low", bus.result_valid, 1'b0);
    end
    check("t4_runs", bus.run_cnt, 16'd4);
    check("t4_pulses", rv_count - rv_mark, 3);

    // Beat in IDLE with no run: sticky stray, next signature unaffected
    check("t6_stray_clear", bus.stray, 1'b0);
    bus.data_valid = 1'b1;
    bus.data_in    = 4'hF;
    step();
    bus.data_valid = 1'b0;
    check("t6_stray", bus.stray, 1'b1);
    check("t6_busy", bus.busy, 1'b0);
    bus.exp_sig   = 32'hFB3EE24C;
    bus.exp_beats = 16'd1;
    bus.ap_start  = 1'b1;
    step();
    bus.data_valid = 1'b1;
    bus.data_in    = 4'h5;
    step();
    bus.data_valid = 1'b0;
    done_and_wait(1'b0, lat);
    check("t6_sig", bus.sig_out, 32'hFB3EE24C);
    check("t6_pass", bus.pass, 1'b1);
    check("t6_stray_held", bus.stray, 1'b1);
    check("t6_runs", bus.run_cnt, 16'd5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_stray_reset", bus.stray, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
